// File: rtl/command_decoder_pkg.sv
// Shared constants, types and helpers for the host command decoder.
package command_decoder_pkg;

  localparam logic [7:0] COMMAND_ID     = 8'hCD;

  localparam logic [7:0] PING_COMMAND   = 8'h00;
  localparam logic [7:0] WRITE_COMMAND  = 8'h01;
  localparam logic [7:0] READ_COMMAND   = 8'h02;
  localparam logic [7:0] CONFIG_COMMAND = 8'h03;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'd0,
    ERR_BAD_ID      = 2'd1,
    ERR_UNKNOWN_CMD = 2'd2,
    ERR_TIMEOUT     = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    HDR_ID,
    HDR_COUNT,
    HDR_ADDR,
    ISSUE,
    PAYLOAD
  } dec_state_e;

  function automatic logic cmd_known(input logic [7:0] cmd);
    return (cmd == PING_COMMAND) || (cmd == WRITE_COMMAND) ||
           (cmd == READ_COMMAND) || (cmd == CONFIG_COMMAND);
  endfunction

  // WRITE and non-empty CONFIG carry payload words after the header.
  function automatic logic cmd_has_payload(input logic [7:0] cmd, input logic [31:0] count);
    return ((cmd == WRITE_COMMAND) || (cmd == CONFIG_COMMAND)) && (count != '0);
  endfunction

endpackage

// File: rtl/command_decoder_ppfifo_reader.sv
// Ping-pong FIFO read-side handshake: picks a filled channel, walks its
// block one word per ack and releases it once all words are consumed.
module command_decoder_ppfifo_reader (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  i_ppfifo_rdy,
  output logic [1:0]  o_ppfifo_act,
  input  logic [23:0] i_ppfifo_size,
  input  logic [31:0] i_ppfifo_data,
  output logic        o_ppfifo_stb,
  output logic        o_valid,
  output logic [31:0] o_data,
  input  logic        i_ack
);

  logic [23:0] count;

  assign o_valid      = (o_ppfifo_act != '0) && (count < i_ppfifo_size);
  assign o_data       = i_ppfifo_data;
  assign o_ppfifo_stb = i_ack && o_valid;

  // Channel activation, word counting and release at end of block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_ppfifo_act <= '0;
      count        <= '0;
    end else if (o_ppfifo_act == '0) begin
      if (i_ppfifo_rdy != '0) begin
        o_ppfifo_act <= i_ppfifo_rdy[0] ? 2'b01 : 2'b10;
        count        <= '0;
      end
    end else if (count == i_ppfifo_size) begin
      o_ppfifo_act <= '0;
    end else if (o_ppfifo_stb) begin
      count <= count + 24'd1;
    end
  end

endmodule

// File: rtl/command_decoder.sv
// Host command decoder: parses 3-word headers from the ping-pong FIFO,
// issues commands to the master and forwards payload words downstream.
module command_decoder
  import command_decoder_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  i_ppfifo_rdy,
  output logic [1:0]  o_ppfifo_act,
  input  logic [23:0] i_ppfifo_size,
  input  logic [31:0] i_ppfifo_data,
  output logic        o_ppfifo_stb,
  input  logic        i_master_ready,
  output logic [7:0]  o_command,
  output logic [7:0]  o_flag,
  output logic [31:0] o_rw_count,
  output logic [31:0] o_address,
  output logic        o_command_rdy_stb,
  input  logic        i_wdata_ready,
  output logic [31:0] o_wdata,
  output logic        o_wdata_stb,
  output logic        o_error_stb,
  output logic [1:0]  o_error_code
);

  dec_state_e  state, state_next;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        want, accept;
  logic        issue, err_set, timed_state, counting;
  err_code_e   err_code_next;
  logic [7:0]  cmd_q, flag_q;
  logic [31:0] count_q, addr_q, remain, tcnt;

  command_decoder_ppfifo_reader u_reader (
    .clk           (clk),
    .rst           (rst),
    .i_ppfifo_rdy  (i_ppfifo_rdy),
    .o_ppfifo_act  (o_ppfifo_act),
    .i_ppfifo_size (i_ppfifo_size),
    .i_ppfifo_data (i_ppfifo_data),
    .o_ppfifo_stb  (o_ppfifo_stb),
    .o_valid       (rd_valid),
    .o_data        (rd_data),
    .i_ack         (accept)
  );

  assign want = (state == HDR_ID) || (state == HDR_COUNT) || (state == HDR_ADDR) ||
                ((state == PAYLOAD) && i_wdata_ready);
  assign accept = want && rd_valid;
  assign timed_state = (state == HDR_COUNT) || (state == HDR_ADDR) || (state == PAYLOAD);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= HDR_ID;
    else      state <= state_next;
  end

  // Next-state, issue and error decisions; timeout overrides the state step.
  always_comb begin
    state_next    = state;
    issue         = 1'b0;
    err_set       = 1'b0;
    err_code_next = ERR_NONE;
    counting      = 1'b0;
    case (state)
      HDR_ID: begin
        if (accept) begin
          if (rd_data[31:24] != COMMAND_ID) begin
            err_set       = 1'b1;
            err_code_next = ERR_BAD_ID;
          end else begin
            state_next = HDR_COUNT;
          end
        end
      end
      HDR_COUNT: begin
        counting = 1'b1;
        if (accept) state_next = HDR_ADDR;
      end
      HDR_ADDR: begin
        counting = 1'b1;
        if (accept) begin
          if (cmd_known(cmd_q)) begin
            state_next = ISSUE;
          end else begin
            err_set       = 1'b1;
            err_code_next = ERR_UNKNOWN_CMD;
            state_next    = HDR_ID;
          end
        end
      end
      ISSUE: begin
        if (i_master_ready) begin
          issue      = 1'b1;
          state_next = cmd_has_payload(cmd_q, count_q) ? PAYLOAD : HDR_ID;
        end
      end
      PAYLOAD: begin
        counting = i_wdata_ready;
        if (accept && (remain == 32'd1)) state_next = HDR_ID;
      end
      default: state_next = HDR_ID;
    endcase
    if (counting && !accept && (TIMEOUT_CYCLES != '0) &&
        (tcnt == TIMEOUT_CYCLES - 32'd1)) begin
      err_set       = 1'b1;
      err_code_next = ERR_TIMEOUT;
      state_next    = HDR_ID;
    end
  end

  // Field latches, output registers, payload and timeout counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q             <= '0;
      flag_q            <= '0;
      count_q           <= '0;
      addr_q            <= '0;
      remain            <= '0;
      tcnt              <= '0;
      o_command         <= '0;
      o_flag            <= '0;
      o_rw_count        <= '0;
      o_address         <= '0;
      o_command_rdy_stb <= 1'b0;
      o_wdata           <= '0;
      o_wdata_stb       <= 1'b0;
      o_error_stb       <= 1'b0;
      o_error_code      <= '0;
    end else begin
      o_command_rdy_stb <= issue;
      o_error_stb       <= err_set;
      o_wdata_stb       <= accept && (state == PAYLOAD);
      if (err_set) o_error_code <= err_code_next;

      if (accept) begin
        case (state)
          HDR_ID: begin
            if (rd_data[31:24] == COMMAND_ID) begin
              flag_q <= rd_data[23:16];
              cmd_q  <= rd_data[7:0];
            end
          end
          HDR_COUNT: count_q <= rd_data;
          HDR_ADDR:  addr_q  <= rd_data;
          PAYLOAD: begin
            o_wdata <= rd_data;
            remain  <= remain - 32'd1;
          end
          default: ;
        endcase
      end

      // Outputs only move at issue so they stay stable while the next header streams in.
      if (issue) begin
        o_command  <= cmd_q;
        o_flag     <= flag_q;
        o_rw_count <= count_q;
        o_address  <= addr_q;
        remain     <= count_q;
      end

      // Held (not cleared) while payload is back-pressured.
      if (!timed_state || accept || err_set) tcnt <= '0;
      else if (counting)                     tcnt <= tcnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_command_decoder.sv
// Directed bench for command_decoder: table of packets plus hand sequences
// for back-pressure, split blocks, timeout and asynchronous reset.
module tb_command_decoder;
  import command_decoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  i_ppfifo_rdy;
  logic [1:0]  o_ppfifo_act;
  logic [23:0] i_ppfifo_size;
  logic [31:0] i_ppfifo_data;
  logic        o_ppfifo_stb;
  logic        i_master_ready;
  logic [7:0]  o_command, o_flag;
  logic [31:0] o_rw_count, o_address;
  logic        o_command_rdy_stb;
  logic        i_wdata_ready;
  logic [31:0] o_wdata;
  logic        o_wdata_stb, o_error_stb;
  logic [1:0]  o_error_code;

  command_decoder #(.TIMEOUT_CYCLES(32'd16)) dut (
    .clk(clk), .rst(rst),
    .i_ppfifo_rdy(i_ppfifo_rdy), .o_ppfifo_act(o_ppfifo_act),
    .i_ppfifo_size(i_ppfifo_size), .i_ppfifo_data(i_ppfifo_data),
    .o_ppfifo_stb(o_ppfifo_stb), .i_master_ready(i_master_ready),
    .o_command(o_command), .o_flag(o_flag), .o_rw_count(o_rw_count),
    .o_address(o_address), .o_command_rdy_stb(o_command_rdy_stb),
    .i_wdata_ready(i_wdata_ready), .o_wdata(o_wdata), .o_wdata_stb(o_wdata_stb),
    .o_error_stb(o_error_stb), .o_error_code(o_error_code)
  );

  always #5 clk = ~clk;

  // FIFO model: blocks loaded by the test, read pointer advanced on strobe.
  logic [31:0] blk [2][16];
  int sz [2] = '{0, 0};
  int base [2] = '{0, 0};
  int load_gen [2] = '{0, 0};
  int taken_gen [2] = '{0, 0};
  int rdcnt [2] = '{0, 0};

  assign i_ppfifo_rdy  = {load_gen[1] != taken_gen[1], load_gen[0] != taken_gen[0]};
  assign i_ppfifo_size = o_ppfifo_act[1] ? 24'(sz[1]) : 24'(sz[0]);
  assign i_ppfifo_data = o_ppfifo_act[1] ? blk[1][(rdcnt[1] - base[1]) & 15]
                                         : blk[0][(rdcnt[0] - base[0]) & 15];

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (o_ppfifo_act[c]) taken_gen[c] <= load_gen[c];
      if (o_ppfifo_act[c] && o_ppfifo_stb) rdcnt[c] <= rdcnt[c] + 1;
    end
  end

  // Output monitor sampled on the falling edge.
  int cnt_rdy = 0, cnt_err = 0;
  bit overlap_seen = 1'b0;
  logic [31:0] wd_log [$];
  always @(negedge clk) begin
    if (o_command_rdy_stb) cnt_rdy++;
    if (o_error_stb) cnt_err++;
    if (o_wdata_stb) wd_log.push_back(o_wdata);
    if (o_command_rdy_stb && o_error_stb) overlap_seen = 1'b1;
  end

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    string            name;
    int               nw;
    logic [5:0][31:0] w;
    int               exp_rdy, exp_err;
    logic [1:0]       exp_code;
    logic [7:0]       exp_cmd, exp_flag;
    logic [31:0]      exp_cnt, exp_addr;
    int               exp_nwd;
  } vec_t;

  vec_t vecs [$];

  task automatic add_vec(input string name, input int nw,
                         input logic [31:0] w0, w1, w2, w3, w4, w5,
                         input int er, ee, input logic [1:0] code,
                         input logic [7:0] cmd, flag, input logic [31:0] cnt, addr,
                         input int nwd);
    vec_t v;
    v.name = name; v.nw = nw;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4; v.w[5] = w5;
    v.exp_rdy = er; v.exp_err = ee; v.exp_code = code;
    v.exp_cmd = cmd; v.exp_flag = flag; v.exp_cnt = cnt; v.exp_addr = addr;
    v.exp_nwd = nwd;
    vecs.push_back(v);
  endtask

  task automatic load(input int ch, input int n, input logic [5:0][31:0] w);
    base[ch] = rdcnt[ch];
    for (int i = 0; i < n; i++) blk[ch][i] = w[i];
    sz[ch] = n;
    load_gen[ch] = load_gen[ch] + 1;
  endtask

  task automatic wait_drain(input string name, input int extra);
    bit done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(posedge clk); #1;
      done = (load_gen[0] == taken_gen[0]) && (load_gen[1] == taken_gen[1]) &&
             (o_ppfifo_act == 2'b00);
    end
    check({name, "_drain"}, 64'(done), 64'd1);
    repeat (extra) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_vec(input vec_t v);
    int s_rdy = cnt_rdy, s_err = cnt_err, s_wd = wd_log.size();
    load(0, v.nw, v.w);
    wait_drain(v.name, 8);
    check({v.name, "_rdy_stbs"}, 64'(cnt_rdy - s_rdy), 64'(v.exp_rdy));
    check({v.name, "_err_stbs"}, 64'(cnt_err - s_err), 64'(v.exp_err));
    if (v.exp_rdy > 0) begin
      check({v.name, "_command"},  64'(o_command),  64'(v.exp_cmd));
      check({v.name, "_flag"},     64'(o_flag),     64'(v.exp_flag));
      check({v.name, "_rw_count"}, 64'(o_rw_count), 64'(v.exp_cnt));
      check({v.name, "_address"},  64'(o_address),  64'(v.exp_addr));
    end
    if (v.exp_err > 0) check({v.name, "_err_code"}, 64'(o_error_code), 64'(v.exp_code));
    check({v.name, "_wdata_n"}, 64'(wd_log.size() - s_wd), 64'(v.exp_nwd));
    for (int i = 0; i < v.exp_nwd && (s_wd + i) < wd_log.size(); i++)
      check({v.name, "_wdata"}, 64'(wd_log[s_wd + i]), 64'(v.w[v.nw - v.exp_nwd + i]));
  endtask

  function automatic logic all_outputs_zero();
    return ({o_ppfifo_act, o_ppfifo_stb, o_command, o_flag, o_rw_count, o_address,
             o_command_rdy_stb, o_wdata, o_wdata_stb, o_error_stb, o_error_code} == '0);
  endfunction

  initial begin
    vec_t v;
    logic [5:0][31:0] w;
    int s_rdy, s_err, s_wd, s_rd;
    bit hit;

    add_vec("ping", 3, 32'hCD00_0000, 0, 0, 0, 0, 0, 1, 0, 2'd0, 8'h00, 8'h00, 0, 0, 0);
    add_vec("read", 3, 32'hCD5A_0002, 32'd16, 32'h2000, 0, 0, 0,
            1, 0, 2'd0, 8'h02, 8'h5A, 32'd16, 32'h2000, 0);
    add_vec("cfg0", 3, 32'hCD01_0003, 32'd0, 32'h7, 0, 0, 0,
            1, 0, 2'd0, 8'h03, 8'h01, 32'd0, 32'h7, 0);
    add_vec("cfg2", 5, 32'hCD02_0003, 32'd2, 32'h40, 32'hAAAA_0001, 32'hAAAA_0002, 0,
            1, 0, 2'd0, 8'h03, 8'h02, 32'd2, 32'h40, 2);
    add_vec("wr1", 4, 32'hCD80_0001, 32'd1, 32'hDEAD_0000, 32'h1234_5678, 0, 0,
            1, 0, 2'd0, 8'h01, 8'h80, 32'd1, 32'hDEAD_0000, 1);
    add_vec("unk", 3, 32'hCD00_007F, 32'd1, 32'h0, 0, 0, 0,
            0, 1, 2'd2, 8'h00, 8'h00, 0, 0, 0);
    add_vec("badid", 4, 32'h1234_5678, 32'hCD07_0002, 32'd3, 32'h300, 0, 0,
            1, 1, 2'd1, 8'h02, 8'h07, 32'd3, 32'h300, 0);

    rst = 1'b0; i_master_ready = 1'b1; i_wdata_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'(all_outputs_zero()), 64'd1);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) apply_vec(vecs[i]);

    // WRITE header in ch0, payload in ch1.
    s_rdy = cnt_rdy; s_wd = wd_log.size();
    w = '0; w[0] = 32'hCD00_0001; w[1] = 32'd4; w[2] = 32'h100;
    load(0, 3, w);
    w = '0; w[0] = 32'hB0; w[1] = 32'hB1; w[2] = 32'hB2; w[3] = 32'hB3;
    load(1, 4, w);
    wait_drain("split", 8);
    check("split_rdy_stbs", 64'(cnt_rdy - s_rdy), 64'd1);
    check("split_address", 64'(o_address), 64'h100);
    check("split_wdata_n", 64'(wd_log.size() - s_wd), 64'd4);
    for (int i = 0; i < 4 && (s_wd + i) < wd_log.size(); i++)
      check("split_wdata", 64'(wd_log[s_wd + i]), 64'(32'hB0 + i));

    // Master busy: issue held off, second block untouched until ready.
    @(posedge clk); #1;
    i_master_ready = 1'b0;
    s_rdy = cnt_rdy;
    w = '0; w[0] = 32'hCD11_0000;
    load(0, 3, w);
    wait_drain("busy1", 0);
    w[0] = 32'hCD44_0000;
    load(1, 3, w);
    s_rd = rdcnt[1];
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("busy_no_stb", 64'(cnt_rdy - s_rdy), 64'd0);
    check("busy_no_reads", 64'(rdcnt[1] - s_rd), 64'd0);
    @(posedge clk); #1;
    i_master_ready = 1'b1;
    @(negedge clk);
    check("busy_stb_not_early", 64'(o_command_rdy_stb), 64'd0);
    @(negedge clk);
    check("busy_stb_next_cycle", 64'(o_command_rdy_stb), 64'd1);
    check("busy_flag1", 64'(o_flag), 64'h11);
    wait_drain("busy2", 8);
    check("busy_rdy_stbs", 64'(cnt_rdy - s_rdy), 64'd2);
    check("busy_flag2", 64'(o_flag), 64'h44);

    // Short WRITE: timeout after payload stalls.
    s_err = cnt_err; s_wd = wd_log.size();
    w = '0; w[0] = 32'hCD00_0001; w[1] = 32'd8; w[2] = 32'h500;
    w[3] = 32'hC0; w[4] = 32'hC1; w[5] = 32'hC2;
    load(0, 6, w);
    wait_drain("tmo", 40);
    check("tmo_err_stbs", 64'(cnt_err - s_err), 64'd1);
    check("tmo_err_code", 64'(o_error_code), 64'd3);
    check("tmo_wdata_n", 64'(wd_log.size() - s_wd), 64'd3);
    v = vecs[1];
    v.name = "after_tmo";
    apply_vec(v);

    // Asynchronous reset in the middle of a payload.
    s_wd = wd_log.size();
    w = '0; w[0] = 32'hCD09_0001; w[1] = 32'd8; w[2] = 32'h600;
    w[3] = 32'hE0; w[4] = 32'hE1; w[5] = 32'hE2;
    load(0, 6, w);
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(posedge clk); #1;
      hit = (wd_log.size() - s_wd) >= 2;
    end
    check("rst_reached_payload", 64'(hit), 64'd1);
    i_wdata_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_async_outputs", 64'(all_outputs_zero()), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1; i_wdata_ready = 1'b1;
    s_rdy = cnt_rdy;
    w = '0; w[0] = 32'hCD33_0000;
    load(0, 3, w);
    wait_drain("post_rst", 8);
    check("post_rst_rdy_stbs", 64'(cnt_rdy - s_rdy), 64'd1);
    check("post_rst_flag", 64'(o_flag), 64'h33);
    check("post_rst_command", 64'(o_command), 64'h00);

    check("no_err_with_rdy", 64'(overlap_seen), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
